// File: rtl/uart_alu_interface_if.sv
// rtl/uart_alu_interface_if.sv - FIFO-side and ALU-side signal bundle for the frame controller
interface uart_alu_interface_if #(
    parameter int DBIT  = 8,
    parameter int NB_OP = 6
) ();
    logic             rx_empty;
    logic [DBIT-1:0]  r_data;
    logic             rd_uart;
    logic             tx_full;
    logic             wr_uart;
    logic [DBIT-1:0]  w_data;
    logic [DBIT-1:0]  alu_a;
    logic [DBIT-1:0]  alu_b;
    logic [NB_OP-1:0] alu_op;
    logic [DBIT-1:0]  alu_result;
    logic             busy;

    modport master (
        input  rx_empty, r_data, tx_full, alu_result,
        output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy
    );

    modport slave (
        output rx_empty, r_data, tx_full, alu_result,
        input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy
    );
endinterface

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - pops A/B/opcode from RX FIFO, drives ALU, pushes result to TX FIFO
module uart_alu_interface #(
    parameter int DBIT  = 8,
    parameter int NB_OP = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_alu_interface_if.master  bus
);
    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [DBIT-1:0]  a_q, b_q, res_q;
    logic [NB_OP-1:0] op_q;
    logic             rd, wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (rd) begin
                case (state_q)
                    GET_A:   a_q  <= bus.r_data;
                    GET_B:   b_q  <= bus.r_data;
                    GET_OP:  op_q <= bus.r_data[NB_OP-1:0];
                    default: ;
                endcase
            end
            if (state_q == EXEC)
                res_q <= bus.alu_result;
        end
    end

    // Pop strobe is gated by reset so nothing is consumed while the block is held in reset.
    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        wr      = 1'b0;
        case (state_q)
            GET_A: begin
                rd = reset & ~bus.rx_empty;
                if (rd) state_d = GET_B;
            end
            GET_B: begin
                rd = reset & ~bus.rx_empty;
                if (rd) state_d = GET_OP;
            end
            GET_OP: begin
                rd = reset & ~bus.rx_empty;
                if (rd) state_d = EXEC;
            end
            EXEC: begin
                state_d = SEND;
            end
            SEND: begin
                wr = ~bus.tx_full;
                if (wr) state_d = GET_A;
            end
            default: begin
                state_d = GET_A;
            end
        endcase
    end

    assign bus.rd_uart = rd;
    assign bus.wr_uart = wr;
    assign bus.w_data  = res_q;
    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;
    assign bus.alu_op  = op_q;
    assign bus.busy    = (state_q != GET_A);
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - directed self-checking bench for uart_alu_interface
module tb_uart_alu_interface;
    logic clk;
    logic reset;

    uart_alu_interface_if #(.DBIT(8), .NB_OP(6)) bus ();

    uart_alu_interface #(.DBIT(8), .NB_OP(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 0x20 add, 0x22 subtract, anything else xor.
    always_comb begin
        case (bus.alu_op)
            6'h20:   bus.alu_result = bus.alu_a + bus.alu_b;
            6'h22:   bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = bus.alu_a ^ bus.alu_b;
        endcase
    end

    logic [7:0] q[$];
    logic [7:0] wr_val[$];
    int         rd_cyc[$];
    int         wr_cyc[$];
    int         cyc, rd_cnt, wr_cnt, both_high;
    int         checks, errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_rx();
        bus.rx_empty = (q.size() == 0);
        bus.r_data   = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        q.push_back(b);
        update_rx();
    endtask

    task automatic clear_stats();
        rd_cnt = 0;
        wr_cnt = 0;
        both_high = 0;
        wr_val.delete();
        rd_cyc.delete();
        wr_cyc.delete();
    endtask

    // One clock: sample strobes on the falling edge, apply FIFO effects just after the rising edge.
    task automatic tick();
        bit pop;
        @(negedge clk);
        pop = bus.rd_uart;
        if (bus.rd_uart && bus.wr_uart) both_high++;
        if (bus.rd_uart) begin
            rd_cnt++;
            rd_cyc.push_back(cyc);
        end
        if (bus.wr_uart) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            wr_val.push_back(bus.w_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop && q.size() > 0) q.delete(0);
        update_rx();
    endtask

    task automatic wait_wr(input int n, input int bound);
        for (int i = 0; i < bound && wr_cnt < n; i++) tick();
    endtask

    task automatic wait_rd(input int n, input int bound);
        for (int i = 0; i < bound && rd_cnt < n; i++) tick();
    endtask

    function automatic logic [31:0] wv(input int i);
        return (i < wr_val.size()) ? {24'h0, wr_val[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rc(input int i);
        return (i < rd_cyc.size()) ? rd_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wc(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [7:0] held;
        int         unstable;

        checks = 0;
        errors = 0;
        cyc = 0;
        clear_stats();
        reset = 1'b0;
        bus.tx_full = 1'b0;
        update_rx();

        // Reset state, with a byte waiting to confirm no pop under reset
        push_byte(8'h77);
        @(negedge clk);
        check("rst_rd_uart", bus.rd_uart, 1'b0);
        check("rst_wr_uart", bus.wr_uart, 1'b0);
        check("rst_w_data",  bus.w_data,  8'h00);
        check("rst_alu_a",   bus.alu_a,   8'h00);
        check("rst_alu_b",   bus.alu_b,   8'h00);
        check("rst_alu_op",  bus.alu_op,  6'h00);
        check("rst_busy",    bus.busy,    1'b0);
        q.delete();
        update_rx();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single frame
        clear_stats();
        push_byte(8'h05);
        push_byte(8'h03);
        push_byte(8'h20);
        wait_wr(1, 20);
        check("single_wr_cnt",  wr_cnt, 1);
        check("single_rd_cnt",  rd_cnt, 3);
        check("single_alu_a",   bus.alu_a, 8'h05);
        check("single_alu_b",   bus.alu_b, 8'h03);
        check("single_alu_op",  bus.alu_op, 6'h20);
        check("single_w_data",  wv(0), 32'h08);
        check("single_latency", wc(0) - rc(2), 32'd2);
        check("single_busy",    bus.busy, 1'b0);

        // Starved RX with 50 idle cycles between bytes
        clear_stats();
        push_byte(8'hFF);
        tick();
        for (int i = 0; i < 50; i++) tick();
        check("starve_rd_after_a", rd_cnt, 1);
        check("starve_alu_a",      bus.alu_a, 8'hFF);
        check("starve_busy",       bus.busy, 1'b1);
        push_byte(8'h01);
        tick();
        for (int i = 0; i < 50; i++) tick();
        check("starve_rd_after_b", rd_cnt, 2);
        check("starve_alu_b",      bus.alu_b, 8'h01);
        check("starve_alu_op_old", bus.alu_op, 6'h20);
        push_byte(8'h20);
        wait_wr(1, 20);
        check("starve_wr_cnt", wr_cnt, 1);
        check("starve_wrap",   wv(0), 32'h00);

        // TX backpressure with the next frame already queued
        clear_stats();
        bus.tx_full = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h20);
        push_byte(8'h01);
        push_byte(8'h01);
        push_byte(8'h20);
        wait_rd(3, 20);
        tick();
        held = bus.w_data;
        check("bp_w_data", held, 8'h33);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.w_data !== held) unstable++;
        end
        check("bp_w_stable", unstable, 0);
        check("bp_no_wr",    wr_cnt, 0);
        check("bp_no_rd",    rd_cnt, 3);
        check("bp_busy",     bus.busy, 1'b1);
        bus.tx_full = 1'b0;
        wait_wr(1, 5);
        check("bp_release_wr", wr_cnt, 1);
        check("bp_release_val", wv(0), 32'h33);
        wait_wr(2, 20);
        check("bp_next_val", wv(1), 32'h02);

        // Back-to-back frames
        clear_stats();
        push_byte(8'h0A);
        push_byte(8'h02);
        push_byte(8'h20);
        push_byte(8'h0A);
        push_byte(8'h02);
        push_byte(8'h22);
        wait_wr(2, 30);
        check("b2b_wr_cnt", wr_cnt, 2);
        check("b2b_val0",   wv(0), 32'h0C);
        check("b2b_val1",   wv(1), 32'h08);
        check("b2b_period", wc(1) - wc(0), 32'd5);
        check("b2b_next_pop", rc(3) - wc(0), 32'd1);
        check("b2b_overlap", both_high, 0);

        // Reset mid-frame after A and B pops
        clear_stats();
        push_byte(8'h40);
        push_byte(8'h50);
        wait_rd(2, 10);
        check("mid_busy_before", bus.busy, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check("mid_alu_a",  bus.alu_a,  8'h00);
        check("mid_alu_b",  bus.alu_b,  8'h00);
        check("mid_alu_op", bus.alu_op, 6'h00);
        check("mid_w_data", bus.w_data, 8'h00);
        check("mid_busy",   bus.busy,   1'b0);
        push_byte(8'h99);
        push_byte(8'h03);
        push_byte(8'h20);
        #1;
        check("mid_rd_held", bus.rd_uart, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_stats();
        wait_wr(1, 20);
        check("mid_rd_cnt", rd_cnt, 3);
        check("mid_new_a",  bus.alu_a, 8'h99);
        check("mid_new_b",  bus.alu_b, 8'h03);
        check("mid_result", wv(0), 32'h9C);

        // Opcode masking
        clear_stats();
        push_byte(8'h07);
        push_byte(8'h02);
        push_byte(8'hE5);
        wait_wr(1, 20);
        check("mask_alu_op", bus.alu_op, 6'h25);
        check("mask_result", wv(0), 32'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Frame controller that sits on the FIFO side of the UART core, between it and the ALU. It pops three bytes from the RX FIFO: operand A, operand B, then opcode. It drives them onto registered ALU inputs, samples the combinational ALU result one cycle later and pushes the result byte into the TX FIFO. One frame is processed at a time. Flow control uses only the FIFO status flags.

## Interface
- `DBIT`, 8, data/operand width; equals the UART core word width.
- `NB_OP`, 6, opcode width; must satisfy NB_OP ≤ DBIT.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `rx_empty`  in  1  RX FIFO empty flag from UART core.
- `r_data`  in  DBIT  RX FIFO head word; valid whenever rx_empty=0.
- `rd_uart`  out  1  RX FIFO pop strobe, one cycle per byte.
- `tx_full`  in  1  TX FIFO full flag from UART core.
- `wr_uart`  out  1  TX FIFO push strobe, one cycle per result.
- `w_data`  out  DBIT  result byte presented with wr_uart.
- `alu_a`  out  DBIT  registered operand A to ALU.
- `alu_b`  out  DBIT  registered operand B to ALU.
- `alu_op`  out  NB_OP  registered opcode to ALU.
- `alu_result`  in  DBIT  combinational ALU output.
- `busy`  out  1  high from first byte popped until result pushed.

## Operation
- States: GET_A → GET_B → GET_OP → EXEC → SEND → GET_A. Reset state is GET_A.
- GET_A / GET_B / GET_OP:
  - `rd_uart` = ~rx_empty. It is combinational from state and the flag.
  - On the edge where rd_uart=1, `r_data` is captured into alu_a, alu_b or alu_op respectively, and the FSM advances.
  - For the opcode, alu_op = r_data[NB_OP-1:0]; upper bits are ignored.
  - While rx_empty=1 the FSM holds and rd_uart=0. There is no timeout.
- EXEC: lasts one cycle, unconditionally. `alu_result` is registered into the result register, which drives `w_data`. The FSM advances to SEND.
- SEND:
  - `wr_uart` = ~tx_full, combinational. On that edge the FSM goes to GET_A.
  - While tx_full=1 the FSM holds. w_data is stable and no RX bytes are popped; they stay queued in the RX FIFO.
- `busy` = 1 in GET_B, GET_OP, EXEC and SEND, and also in GET_A... no: busy = 0 in GET_A, 1 in all other states.
- alu_a, alu_b and alu_op hold their values until overwritten by the next frame. The ALU therefore sees stable inputs throughout EXEC and SEND.
- rd_uart and wr_uart are never high in the same cycle. At most one FIFO access happens per cycle.

## Timing
- Reset values: rd_uart=0, wr_uart=0, w_data=0, alu_a=0, alu_b=0, alu_op=0, busy=0, state=GET_A.
- Reset asserted mid-frame: the partial frame is discarded. Bytes already popped are lost; bytes still in the RX FIFO are processed as a new frame after reset deasserts.
- Pop throughput: one byte per cycle when the RX FIFO holds data. Three back-to-back bytes are popped in cycles N, N+1, N+2.
- Opcode popped in cycle N, then:
  - alu_op is valid in N+1 (EXEC), and the result is registered at the end of N+1.
  - w_data is valid in N+2.
  - wr_uart rises in N+2 if tx_full=0.
- Minimum frame period is 5 cycles: 3 pops, 1 EXEC, 1 push. The next frame's first pop can occur in the cycle after wr_uart.
- Interaction with the UART core flags:
  - rx_empty deasserting while in EXEC or SEND has no effect until GET_A.
  - tx_full changing while not in SEND is ignored.
- The ALU combinational path (alu_a/alu_b/alu_op → alu_result) must settle within one clock period.

## Test plan
- Single frame: push 0x05, 0x03, 0x20 with a bench ALU model computing a+b. Required: alu_a=0x05, alu_b=0x03, alu_op=6'h20; exactly three rd_uart pulses; one wr_uart pulse with w_data=0x08, 2 cycles after the opcode pop; busy returns to 0.
- Starved RX: deliver bytes 0xFF, 0x01, 0x20 with 50 idle cycles (rx_empty=1) between each. Required: no rd_uart pulses during the gaps and no spurious captures; result 0x00 (8-bit wrap).
- TX backpressure: hold tx_full=1 for 20 cycles on entering SEND. Required: wr_uart=0 and w_data stable throughout; no rd_uart pulses even though the next frame is queued; a single push on release.
- Back-to-back frames: six bytes preloaded (0x0A, 0x02, 0x20, 0x0A, 0x02, 0x22), ALU models 0x20=add and 0x22=sub. Required: outputs 0x0C then 0x08; frame period exactly 5 cycles; rd_uart and wr_uart never both high.
- Reset mid-frame: pull reset low after the A and B pops. Required: all outputs 0 immediately (asynchronously); after release, the next three bytes form a fresh frame starting at GET_A.
- Opcode masking: opcode byte 0xE5. Required: alu_op=6'h25.
